clk_div_multi: RTL

//   Multi-channel programmable clock-enable / tick generator. Each of NUM_CH

---
 rtl/clk_div_multi.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable / tick generator.
// Each channel divides clk by a runtime divisor with a programmable high time.
module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]      cfg_div,
  input  logic [CNT_W-1:0]      cfg_high,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic                  sync_req,
  output logic [NUM_CH-1:0]     clk_out,
  output logic [NUM_CH-1:0]     tick
);

  localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int              CH_SPAN  = 2 ** CH_W;
  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_DIV / 2);

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    if (d < CNT_W'(2)) begin
      return CNT_W'(2);
    end else begin
      return d;
    end
  endfunction

  function automatic logic [CNT_W-1:0] clamp_high(input logic [CNT_W-1:0] h,
                                                 input logic [CNT_W-1:0] d);
    if (h > d) begin
      return d;
    end else begin
      return h;
    end
  endfunction

  logic [CNT_W-1:0]  cnt_r     [NUM_CH];
  logic [CNT_W-1:0]  cnt_s     [NUM_CH];
  logic [CNT_W-1:0]  div_r     [NUM_CH];
  logic [CNT_W-1:0]  div_s     [NUM_CH];
  logic [CNT_W-1:0]  high_r    [NUM_CH];
  logic [CNT_W-1:0]  high_s    [NUM_CH];
  logic [CNT_W-1:0]  sh_div_r  [NUM_CH];
  logic [CNT_W-1:0]  sh_div_s  [NUM_CH];
  logic [CNT_W-1:0]  sh_high_r [NUM_CH];
  logic [CNT_W-1:0]  sh_high_s [NUM_CH];
  logic [NUM_CH-1:0] pend_r;
  logic [NUM_CH-1:0] pend_s;
  logic [NUM_CH-1:0] run_r;
  logic [NUM_CH-1:0] clk_out_r;
  logic [NUM_CH-1:0] clk_out_s;
  logic [NUM_CH-1:0] tick_r;
  logic [NUM_CH-1:0] tick_s;
  logic [NUM_CH-1:0] acc_s;
  logic [NUM_CH-1:0] wrap_s;
  logic [NUM_CH-1:0] apply_s;
  logic [CH_SPAN-1:0] pend_ext_s;
  logic [CNT_W-1:0]  new_div_s;
  logic [CNT_W-1:0]  new_high_s;
  logic              cfg_ready_s;

  // Clamp incoming config and derive ready; unused channel codes read as busy.
  always_comb begin
    new_div_s  = clamp_div(cfg_div);
    new_high_s = clamp_high(cfg_high, new_div_s);
    pend_ext_s = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      pend_ext_s[i] = pend_r[i];
    end
    cfg_ready_s = ~pend_ext_s[cfg_ch];
  end

  // Per-channel next state: shadow capture, period-edge apply, counter, outputs.
  always_comb begin
    acc_s   = '0;
    wrap_s  = '0;
    apply_s = '0;
    pend_s  = pend_r;
    clk_out_s = '0;
    tick_s    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc_s[i]   = cfg_valid & cfg_ready_s & (cfg_ch == CH_W'(i));
      wrap_s[i]  = run_r[i] & (cnt_r[i] == (div_r[i] - CNT_W'(1)));
      // Any period start (enable, sync, wrap) or a disabled channel takes new config.
      apply_s[i] = ~ch_en[i] | ~run_r[i] | sync_req | wrap_s[i];

      if (acc_s[i]) begin
        sh_div_s[i]  = new_div_s;
        sh_high_s[i] = new_high_s;
      end else begin
        sh_div_s[i]  = sh_div_r[i];
        sh_high_s[i] = sh_high_r[i];
      end

      if (apply_s[i] & (pend_r[i] | acc_s[i])) begin
        div_s[i]  = sh_div_s[i];
        high_s[i] = sh_high_s[i];
        pend_s[i] = 1'b0;
      end else begin
        div_s[i]  = div_r[i];
        high_s[i] = high_r[i];
        pend_s[i] = pend_r[i] | acc_s[i];
      end

      if (apply_s[i]) begin
        cnt_s[i] = '0;
      end else begin
        cnt_s[i] = cnt_r[i] + CNT_W'(1);
      end

      clk_out_s[i] = ch_en[i] & (cnt_s[i] < high_s[i]);
      tick_s[i]    = ch_en[i] & (cnt_s[i] == '0);
    end
  end

  // State and registered outputs; reset reverts every channel to the default divisor.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i]     <= '0;
        div_r[i]     <= DEF_DIV;
        high_r[i]    <= DEF_HIGH;
        sh_div_r[i]  <= DEF_DIV;
        sh_high_r[i] <= DEF_HIGH;
      end
      pend_r    <= '0;
      run_r     <= '0;
      clk_out_r <= '0;
      tick_r    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i]     <= cnt_s[i];
        div_r[i]     <= div_s[i];
        high_r[i]    <= high_s[i];
        sh_div_r[i]  <= sh_div_s[i];
        sh_high_r[i] <= sh_high_s[i];
      end
      pend_r    <= pend_s;
      run_r     <= ch_en;
      clk_out_r <= clk_out_s;
      tick_r    <= tick_s;
    end
  end

  assign cfg_ready = cfg_ready_s;
  assign clk_out   = clk_out_r;
  assign tick      = tick_r;

endmodule
